ej32_mem_arb: RTL

- Sequencing arbiter for the single 8-bit SPRAM port shared by the instruction fetch path (IU), the load/store unit (LS) and a host/debug port (DBG).
- Grants one requester at a time and runs a byte burst of 1-4 beats at incrementing addresses, so LS can move a 32-bit cell as 4 bytes.
- Returns read data with a fixed 1-cycle latency.
- Sits between the EJ32 core units and the spram8 memory bus.

---
 rtl/ej32_mem_arb.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ej32_mem_arb.sv
// Sequencing arbiter for the shared 8-bit SPRAM port (IU, LS, DBG), with byte bursts of 1-4 beats.
// Define EJ32_ARB_RR_EN for round-robin arbitration; otherwise fixed LS > IU > DBG with a DBG starvation guard.
module ej32_mem_arb #(
    parameter int ASZ    = 17,
    parameter int STARVE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [2:0]       we,
    input  logic [5:0]       len,
    input  logic [3*ASZ-1:0] addr,
    input  logic [23:0]      wd,
    output logic [2:0]       gnt,
    output logic [2:0]       ack,
    output logic [2:0]       rvalid,
    output logic [7:0]       rdata,
    output logic             busy,
    output logic             m_en,
    output logic             m_we,
    output logic [ASZ-1:0]   m_addr,
    output logic [7:0]       m_wd,
    input  logic [7:0]       m_rd
);

    localparam int SW = $clog2(STARVE + 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t         state_r, state_s;
    logic [1:0]     owner_r, owner_s;
    logic [ASZ-1:0] base_r, base_s;
    logic [1:0]     len_r, len_s;
    logic           we_r, we_s;
    logic [1:0]     beat_r, beat_s;
    logic [SW-1:0]  starve_r, starve_s;
    logic [1:0]     win_s;

    logic [2:0]     gnt_s, ack_s, rvalid_s;
    logic           busy_s, m_en_s, m_we_s;
    logic [ASZ-1:0] m_addr_s;
    logic [7:0]     m_wd_s;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    function automatic logic [ASZ-1:0] sel_addr(input logic [3*ASZ-1:0] a, input logic [1:0] idx);
        case (idx)
            2'd0:    sel_addr = a[ASZ-1:0];
            2'd1:    sel_addr = a[2*ASZ-1:ASZ];
            2'd2:    sel_addr = a[3*ASZ-1:2*ASZ];
            default: sel_addr = {ASZ{1'b0}};
        endcase
    endfunction

    function automatic logic [1:0] sel_len(input logic [5:0] l, input logic [1:0] idx);
        case (idx)
            2'd0:    sel_len = l[1:0];
            2'd1:    sel_len = l[3:2];
            2'd2:    sel_len = l[5:4];
            default: sel_len = 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] sel_wd(input logic [23:0] d, input logic [1:0] idx);
        case (idx)
            2'd0:    sel_wd = d[7:0];
            2'd1:    sel_wd = d[15:8];
            2'd2:    sel_wd = d[23:16];
            default: sel_wd = 8'h00;
        endcase
    endfunction

`ifdef EJ32_ARB_RR_EN
    // Search starts at the requester after the last owner; walking backwards lets the nearest one win.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] w;
        w = 2'd0;
        for (int i = 3; i >= 1; i--) begin
            int k;
            k = (int'(last) + i) % 3;
            if (r[k]) begin
                w = k[1:0];
            end
        end
        return w;
    endfunction

    // Winner selection (round-robin)
    always_comb begin
        win_s = pick(req, owner_r);
    end

    // Starvation counter is idle in round-robin mode
    always_comb begin
        starve_s = {SW{1'b0}};
    end
`else
    // Winner selection: promoted DBG, then LS > IU > DBG
    always_comb begin
        win_s = 2'd2;
        if (req[2] && (starve_r >= SW'(STARVE))) begin
            win_s = 2'd2;
        end else if (req[1]) begin
            win_s = 2'd1;
        end else if (req[0]) begin
            win_s = 2'd0;
        end else begin
            win_s = 2'd2;
        end
    end

    // Count IDLE arbitrations that DBG requests but loses; clear on DBG grant or DBG idle
    always_comb begin
        starve_s = starve_r;
        if (!req[2]) begin
            starve_s = {SW{1'b0}};
        end else if (state_r == IDLE) begin
            if (win_s == 2'd2) begin
                starve_s = {SW{1'b0}};
            end else if (starve_r < SW'(STARVE)) begin
                starve_s = starve_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                starve_s = starve_r;
            end
        end else begin
            starve_s = starve_r;
        end
    end
`endif

    // Next state plus the registered-output values for the beat visible after the coming edge
    always_comb begin
        state_s  = state_r;
        owner_s  = owner_r;
        base_s   = base_r;
        len_s    = len_r;
        we_s     = we_r;
        beat_s   = beat_r;
        gnt_s    = 3'b000;
        ack_s    = 3'b000;
        busy_s   = 1'b0;
        m_en_s   = 1'b0;
        m_we_s   = 1'b0;
        m_addr_s = {ASZ{1'b0}};
        m_wd_s   = 8'h00;
        case (state_r)
            IDLE: begin
                if (req != 3'b000) begin
                    state_s  = BURST;
                    owner_s  = win_s;
                    base_s   = sel_addr(addr, win_s);
                    len_s    = sel_len(len, win_s);
                    we_s     = we[win_s];
                    beat_s   = 2'd0;
                    gnt_s    = onehot(win_s);
                    ack_s    = onehot(win_s);
                    busy_s   = 1'b1;
                    m_en_s   = 1'b1;
                    m_we_s   = we[win_s];
                    m_addr_s = sel_addr(addr, win_s);
                    m_wd_s   = sel_wd(wd, win_s);
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                // Last beat done, or owner withdrew: the visible beat completes and the burst ends
                if ((beat_r == len_r) || !req[owner_r]) begin
                    state_s = IDLE;
                end else begin
                    beat_s   = beat_r + 2'd1;
                    gnt_s    = onehot(owner_r);
                    ack_s    = onehot(owner_r);
                    busy_s   = 1'b1;
                    m_en_s   = 1'b1;
                    m_we_s   = we_r;
                    m_addr_s = base_r + {{(ASZ-2){1'b0}}, beat_s};
                    m_wd_s   = sel_wd(wd, owner_r);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Read byte arrives one cycle after a read access, tagged with the owner of that access
    always_comb begin
        rvalid_s = 3'b000;
        if (m_en && !m_we) begin
            rvalid_s = onehot(owner_r);
        end else begin
            rvalid_s = 3'b000;
        end
    end

    // FSM state and latched burst context
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            owner_r  <= 2'd0;
            base_r   <= {ASZ{1'b0}};
            len_r    <= 2'd0;
            we_r     <= 1'b0;
            beat_r   <= 2'd0;
            starve_r <= {SW{1'b0}};
        end else begin
            state_r  <= state_s;
            owner_r  <= owner_s;
            base_r   <= base_s;
            len_r    <= len_s;
            we_r     <= we_s;
            beat_r   <= beat_s;
            starve_r <= starve_s;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt    <= 3'b000;
            ack    <= 3'b000;
            rvalid <= 3'b000;
            busy   <= 1'b0;
            m_en   <= 1'b0;
            m_we   <= 1'b0;
            m_addr <= {ASZ{1'b0}};
            m_wd   <= 8'h00;
        end else begin
            gnt    <= gnt_s;
            ack    <= ack_s;
            rvalid <= rvalid_s;
            busy   <= busy_s;
            m_en   <= m_en_s;
            m_we   <= m_we_s;
            m_addr <= m_addr_s;
            m_wd   <= m_wd_s;
        end
    end

    assign rdata = m_rd;

endmodule
